// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator and its upstream multiplier.
// Operand-derived widths live here so both blocks size their buses alike.
package product_accumulator_pkg;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Product width: both operands plus two guard bits
    function automatic int zw(input int ml, input int mc);
        return ml + mc + 2;
    endfunction

    function automatic int aw(input int ml, input int mc, input int n);
        return zw(ml, mc) + clog2(n);
    endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums groups of Num_terms products and hands each total to a
// valid/ready output register, stalling upstream when both slots are full.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter  int Multiplier_length   = 4,
    parameter  int Multiplicand_length = 4,
    parameter  int Num_terms           = 4,
    localparam int ZW = zw(Multiplier_length, Multiplicand_length),
    localparam int AW = aw(Multiplier_length, Multiplicand_length, Num_terms),
    localparam int CW = clog2(Num_terms + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [ZW-1:0] z,
    input  logic          z_valid,
    output logic          in_ready,
    output logic [AW-1:0] acc,
    output logic          acc_valid,
    input  logic          acc_ready,
    output logic [CW-1:0] term_cnt,
    output logic          overflow
);

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [AW-1:0] sum;
    logic [AW-1:0] sum_nxt;
    logic [AW-1:0] sum_add;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_add;
    logic [AW-1:0] acc_nxt;
    logic          acc_valid_nxt;
    logic          overflow_nxt;
    logic          take;
    logic          out_free;
    logic          last;

    assign in_ready = (state == ACCUM);

    always_comb begin
        take          = acc_valid & acc_ready;
        out_free      = ~acc_valid | take;
        sum_add       = sum + AW'(z);
        cnt_add       = term_cnt + CW'(1);
        last          = (cnt_add == CW'(Num_terms));
        state_nxt     = state;
        sum_nxt       = sum;
        cnt_nxt       = term_cnt;
        acc_nxt       = acc;
        acc_valid_nxt = acc_valid & ~acc_ready;
        overflow_nxt  = overflow;
        unique case (state)
            ACCUM: begin
                if (z_valid) begin
                    if (last && out_free) begin
                        acc_nxt       = sum_add;
                        acc_valid_nxt = 1'b1;
                        sum_nxt       = '0;
                        cnt_nxt       = '0;
                    end else begin
                        // Full total with output busy parks here until drained
                        if (last) state_nxt = HOLD;
                        sum_nxt = sum_add;
                        cnt_nxt = cnt_add;
                    end
                end
            end
            HOLD: begin
                if (z_valid) overflow_nxt = 1'b1;
                if (take) begin
                    acc_nxt       = sum;
                    acc_valid_nxt = 1'b1;
                    sum_nxt       = '0;
                    cnt_nxt       = '0;
                    state_nxt     = ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            sum       <= '0;
            term_cnt  <= '0;
            acc       <= '0;
            acc_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            sum       <= sum_nxt;
            term_cnt  <= cnt_nxt;
            acc       <= acc_nxt;
            acc_valid <= acc_valid_nxt;
            overflow  <= overflow_nxt;
        end
    end

endmodule
